// File: rtl/i2c_pkg.sv
// Shared widths, FSM state encoding and small helpers for the I2C memory subsystem.
// Both the bus master and the memory slave import these.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int MEM_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } slave_state_t;

  // Word pointer advance; the 7-bit width makes 127 roll over to 0.
  function automatic logic [I2C_ADDR_W-1:0] addr_inc(input logic [I2C_ADDR_W-1:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/i2c_mem_slave_if.sv
// Slave-side bus bundle.
// Carries SCL from the master and the slave's status outputs back to it.
interface i2c_mem_slave_if;
  logic                          scl;
  logic                          busy;
  logic                          done;
  logic [i2c_pkg::I2C_ADDR_W-1:0] memAddr;

  modport slave  (input scl, output busy, output done, output memAddr);
  modport master (output scl, input busy, input done, input memAddr);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchronizers plus one edge-detect stage.
// Produces the SCL edge strobes and START/STOP detections the slave FSM runs on.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;

  // Synchronizer chains and the previous-value flops; an idle bus reads high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both sides of the SDA edge to count as START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C memory target: 128 x 8 register file addressed directly by the 7-bit address field.
// The slave never stretches SCL and only ever pulls SDA low.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [I2C_DATA_W-1:0] MEM_INIT    = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  i2c_mem_slave_if.slave  bus,
  inout  wire             sda
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  slave_state_t          state_q;
  logic [3:0]            bit_cnt_q;
  logic [I2C_DATA_W-1:0] shift_q;
  logic                  rw_q;
  logic                  sda_oe_q;
  logic                  busy_q;
  logic                  done_q;
  logic [I2C_ADDR_W-1:0] mem_addr_q;
  logic [I2C_DATA_W-1:0] mem_q [MEM_DEPTH];

  logic                  mem_we_d;
  logic [I2C_DATA_W-1:0] mem_wdata_d;
  logic [I2C_ADDR_W-1:0] mem_addr_inc_s;
  logic [I2C_DATA_W-1:0] mem_rd_s;
  logic [I2C_DATA_W-1:0] mem_nxt_s;

  assign mem_addr_inc_s = addr_inc(mem_addr_q);
  assign mem_rd_s       = mem_q[mem_addr_q];
  assign mem_nxt_s      = mem_q[mem_addr_inc_s];

  // Commit strobe: the 8th data rise of a write, unless a START/STOP pre-empts it.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_wdata_d = {shift_q[6:0], sda_s};
    if ((state_q == WR_DATA) && scl_rise && (bit_cnt_q == 4'd7) && !start_det && !stop_det) begin
      mem_we_d = 1'b1;
    end else begin
      mem_we_d = 1'b0;
    end
  end

  // Register file; the whole array returns to MEM_INIT on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= MEM_INIT;
      end
    end else if (mem_we_d) begin
      mem_q[mem_addr_q] <= mem_wdata_d;
    end
  end

  // Protocol FSM: START/STOP override every state, bits move on synchronized SCL edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= 7'd0;
    end else begin
      done_q <= mem_we_d;
      if (stop_det) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= 4'd0;
        shift_q   <= 8'h00;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise && (bit_cnt_q < 4'd8)) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                mem_addr_q <= shift_q[6:0];
                rw_q       <= sda_s;
              end
            end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
              sda_oe_q <= 1'b1;
              state_q  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                // First read bit goes out on the same fall that ends the ACK.
                state_q   <= RD_DATA;
                sda_oe_q  <= ~mem_rd_s[7];
                shift_q   <= {mem_rd_s[6:0], 1'b0};
                bit_cnt_q <= 4'd1;
              end else begin
                state_q   <= WR_DATA;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && (bit_cnt_q < 4'd8)) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
              sda_oe_q <= 1'b1;
              state_q  <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q   <= 1'b0;
              mem_addr_q <= mem_addr_inc_s;
              bit_cnt_q  <= 4'd0;
              state_q    <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[7];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              done_q <= 1'b1;
              if (!sda_s) begin
                mem_addr_q <= mem_addr_inc_s;
                shift_q    <= mem_nxt_s;
                bit_cnt_q  <= 4'd0;
                state_q    <= RD_DATA;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: begin
          end
          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.memAddr = mem_addr_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: a bit-banged I2C master drives random transfers and
// checks them against an array model of the memory and word pointer.
module tb_i2c_mem_slave;
  import i2c_pkg::*;

  localparam int HALF = 20;
  localparam int QTR  = 10;

  logic clk = 1'b0;
  logic rst;
  logic m_sda_low;
  wire  sda;

  i2c_mem_slave_if bus();

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_mem_slave #(.SYNC_STAGES(2), .MEM_INIT(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sda (sda)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int done_wide    = 0;
  logic done_prev  = 1'b0;

  logic [7:0] ref_mem [128];
  int         ref_ptr;
  logic [7:0] wdata [4];
  logic [7:0] rdata [4];

  // Count done pulses and any pulse longer than one cycle.
  always @(posedge clk) begin
    done_prev <= bus.done;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.done === 1'b1 && done_prev === 1'b1) done_wide <= done_wide + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_ptr = 0;
  endtask

  task automatic m_start();
    m_sda_low = 1'b0; wait_clk(QTR);
    bus.scl = 1'b1;   wait_clk(HALF);
    m_sda_low = 1'b1; wait_clk(HALF);
    bus.scl = 1'b0;   wait_clk(QTR);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1; wait_clk(QTR);
    bus.scl = 1'b1;   wait_clk(HALF);
    m_sda_low = 1'b0; wait_clk(HALF);
  endtask

  task automatic m_write_bit(input logic b);
    m_sda_low = ~b; wait_clk(QTR);
    bus.scl = 1'b1; wait_clk(HALF);
    bus.scl = 1'b0; wait_clk(QTR);
  endtask

  task automatic m_read_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(QTR);
    bus.scl = 1'b1;   wait_clk(HALF / 2);
    b = sda;          wait_clk(HALF / 2);
    bus.scl = 1'b0;   wait_clk(QTR);
  endtask

  task automatic m_write_byte(input logic [7:0] b, output bit ack);
    logic bv;
    for (int i = 7; i >= 0; i--) m_write_bit(b[i]);
    m_read_bit(bv);
    ack = (bv === 1'b0);
  endtask

  task automatic m_read_byte(output logic [7:0] b, input bit ack);
    logic bv;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      m_read_bit(bv);
      b[i] = bv;
    end
    m_write_bit(ack ? 1'b0 : 1'b1);
  endtask

  task automatic do_write(input logic [6:0] addr, input int n, output int acks);
    bit a;
    acks = 0;
    m_start();
    m_write_byte({addr, 1'b0}, a); acks += int'(a);
    for (int i = 0; i < n; i++) begin
      m_write_byte(wdata[i], a); acks += int'(a);
      ref_mem[(int'(addr) + i) % 128] = wdata[i];
    end
    m_stop();
    ref_ptr = (int'(addr) + n) % 128;
  endtask

  task automatic do_read(input logic [6:0] addr, input int n, output bit addr_ack);
    m_start();
    m_write_byte({addr, 1'b1}, addr_ack);
    for (int i = 0; i < n; i++) m_read_byte(rdata[i], i < n - 1);
    m_stop();
    ref_ptr = (int'(addr) + n - 1) % 128;
  endtask

  task automatic test_reset();
    bit a;
    rst = 1'b0; m_sda_low = 1'b0; bus.scl = 1'b1;
    model_reset();
    wait_clk(500);
    rst = 1'b1;
    wait_clk(5);
    tests_run++; if (sda !== 1'b1) begin tests_failed++; $display("FAIL reset_sda: got %b want 1", sda); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
    tests_run++; if (bus.memAddr !== 7'h00) begin tests_failed++; $display("FAIL reset_memaddr: got %h want 00", bus.memAddr); end
    do_read(7'h55, 1, a);
    tests_run++; if (rdata[0] !== ref_mem[8'h55]) begin tests_failed++; $display("FAIL reset_mem55: got %h want %h", rdata[0], ref_mem[8'h55]); end
  endtask

  task automatic test_single_write();
    bit a;
    int d0 = done_cnt;
    m_start();
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_start: got %b want 1", bus.busy); end
    m_write_byte({7'h55, 1'b0}, a);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL wr_addr_ack: got %b want 1", a); end
    m_write_byte(8'h2F, a);
    ref_mem[8'h55] = 8'h2F;
    ref_ptr = 8'h56;
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL wr_data_ack: got %b want 1", a); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_mid: got %b want 1", bus.busy); end
    m_stop();
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL wr_done_count: got %0d want 1", done_cnt - d0); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_stop: got %b want 0", bus.busy); end
    tests_run++; if (int'(bus.memAddr) !== ref_ptr) begin tests_failed++; $display("FAIL wr_memaddr: got %h want %h", bus.memAddr, ref_ptr); end
  endtask

  task automatic test_read_back();
    bit a;
    logic [7:0] b;
    int d0 = done_cnt;
    m_start();
    m_write_byte({7'h55, 1'b1}, a);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL rd_ackerr: got ack %b want 1", a); end
    m_read_byte(b, 1'b0);
    tests_run++; if (b !== ref_mem[8'h55]) begin tests_failed++; $display("FAIL rd_data: got %h want %h", b, ref_mem[8'h55]); end
    tests_run++; if (sda !== 1'b1) begin tests_failed++; $display("FAIL rd_nack_release: got %b want 1", sda); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rd_wait_stop_busy: got %b want 1", bus.busy); end
    m_stop();
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL rd_done_count: got %0d want 1", done_cnt - d0); end
    tests_run++; if (bus.memAddr !== 7'h55) begin tests_failed++; $display("FAIL rd_memaddr: got %h want 55", bus.memAddr); end
  endtask

  task automatic test_burst_wrap();
    int acks;
    bit a;
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    do_write(7'h7F, 2, acks);
    tests_run++; if (acks !== 3) begin tests_failed++; $display("FAIL wrap_acks: got %0d want 3", acks); end
    tests_run++; if (int'(bus.memAddr) !== ref_ptr) begin tests_failed++; $display("FAIL wrap_memaddr: got %h want %h", bus.memAddr, ref_ptr); end
    do_read(7'h7F, 2, a);
    tests_run++; if (rdata[0] !== ref_mem[127]) begin tests_failed++; $display("FAIL wrap_mem7f: got %h want %h", rdata[0], ref_mem[127]); end
    tests_run++; if (rdata[1] !== ref_mem[0]) begin tests_failed++; $display("FAIL wrap_mem00: got %h want %h", rdata[1], ref_mem[0]); end
  endtask

  task automatic test_repeated_start();
    bit a;
    logic [7:0] b;
    logic [7:0] partial = 8'hC3;
    int d0 = done_cnt;
    m_start();
    m_write_byte({7'h10, 1'b0}, a);
    for (int i = 7; i >= 4; i--) m_write_bit(partial[i]);
    m_start();
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rs_busy: got %b want 1", bus.busy); end
    tests_run++; if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL rs_no_done: got %0d want 0", done_cnt - d0); end
    m_write_byte({7'h10, 1'b1}, a);
    tests_run++; if (a !== 1'b1) begin tests_failed++; $display("FAIL rs_addr_ack: got %b want 1", a); end
    m_read_byte(b, 1'b0);
    m_stop();
    tests_run++; if (b !== ref_mem[8'h10]) begin tests_failed++; $display("FAIL rs_mem10: got %h want %h", b, ref_mem[8'h10]); end
  endtask

  task automatic test_random();
    int acks;
    bit a;
    logic [6:0] addr;
    int n;
    int d0;
    for (int it = 0; it < 16; it++) begin
      addr = 7'($urandom_range(0, 127));
      n    = $urandom_range(1, 3);
      d0   = done_cnt;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
        do_write(addr, n, acks);
        tests_run++; if (acks !== n + 1) begin tests_failed++; $display("FAIL rnd_wr_acks it%0d: got %0d want %0d", it, acks, n + 1); end
      end else begin
        do_read(addr, n, a);
        for (int i = 0; i < n; i++) begin
          tests_run++;
          if (rdata[i] !== ref_mem[(int'(addr) + i) % 128]) begin
            tests_failed++;
            $display("FAIL rnd_rd_data it%0d byte%0d: got %h want %h", it, i, rdata[i], ref_mem[(int'(addr) + i) % 128]);
          end
        end
      end
      tests_run++; if (done_cnt - d0 !== n) begin tests_failed++; $display("FAIL rnd_done it%0d: got %0d want %0d", it, done_cnt - d0, n); end
      tests_run++; if (int'(bus.memAddr) !== ref_ptr) begin tests_failed++; $display("FAIL rnd_memaddr it%0d: got %h want %h", it, bus.memAddr, ref_ptr); end
    end
    tests_run++; if (done_wide !== 0) begin tests_failed++; $display("FAIL done_width: got %0d wide pulses want 0", done_wide); end
  endtask

  task automatic test_reset_mid_read();
    int acks;
    bit a;
    wdata[0] = 8'h3C;
    do_write(7'h20, 1, acks);
    m_start();
    m_write_byte({7'h20, 1'b1}, a);
    tests_run++; if (sda !== 1'b0) begin tests_failed++; $display("FAIL mid_sda_driven: got %b want 0", sda); end
    rst = 1'b0;
    #1;
    tests_run++; if (sda !== 1'b1) begin tests_failed++; $display("FAIL mid_sda_release: got %b want 1", sda); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    wait_clk(10);
    m_sda_low = 1'b0; bus.scl = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    model_reset();
    wait_clk(10);
    do_read(7'h20, 1, a);
    tests_run++; if (rdata[0] !== ref_mem[8'h20]) begin tests_failed++; $display("FAIL mid_mem_init: got %h want %h", rdata[0], ref_mem[8'h20]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_burst_wrap();
    test_repeated_start();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
